debayer_stream: RTL
===================

// Module: debayer_stream
// PURPOSE
//   Streaming 2x2 debayer. Accepts one raw Bayer intensity sample per handshake,
//   raster order, and keeps one image row in an internal line buffer. Each
//   completed 2x2 quad produces one registered ARGB pixel, so output is half
//   resolution. Bayer phase and green rounding are set by parameters. Sits
//   between the sensor/frame-read path and the ARGB frame writer.
// PARAMETERS
//   PIX_W       8       bits per raw sample and per output colour channel
//   IMG_WIDTH   640     input samples per row; must be even, >= 2
//   IMG_HEIGHT  480     input rows per frame; must be even, >= 2
//   BAYER_MODE  0       quad phase: 0=RGGB 1=GRBG 2=GBRG 3=BGGR
//   ROUND       0       0: G=(ga+gb)>>1 (truncate); 1: G=(ga+gb+1)>>1
//   ALPHA       8'hFF   constant alpha byte (PIX_W bits wide)
// PORTS
//   clk        in   1          clock, rising edge
//   rst        in   1          asynchronous reset, active-high
//   in_valid   in   1          in_pixel/in_sof valid
//   in_ready   out  1          block accepts a sample this cycle
//   in_pixel   in   PIX_W      raw Bayer sample
//   in_sof     in   1          sample is row 0, column 0 of a frame
//   out_valid  out  1          out_pixel valid
//   out_ready  in   1          downstream accepts out_pixel
//   out_pixel  out  4*PIX_W    {ALPHA, R, G, B}
//   out_eol    out  1          qualifies out_pixel: last quad of a quad-row
//   out_eof    out  1          qualifies out_pixel: last quad of the frame
//   sof_err    out  1          1-cycle pulse: in_sof accepted mid-frame
// BEHAVIOUR
//   - Reset values: out_valid, out_pixel, out_eol, out_eof, sof_err, the col/row
//     counters and the hold register are all 0. The line buffer is not reset.
//   - Accept occurs when in_valid && in_ready. in_ready = !out_valid || out_ready.
//     This rule applies on every row, which keeps the logic uniform.
//   - Counters: col runs 0..IMG_WIDTH-1 and row runs 0..IMG_HEIGHT-1. Both advance
//     only on accept. col wraps to 0 and increments row. After the last sample
//     of the frame, row also wraps to 0.
//   - in_sof accepted: the sample is treated as (0,0) and the counters restart.
//     If the counters were not already at (0,0), sof_err pulses on the next cycle.
//     in_sof = 0 at (0,0) is legal; there is no error.
//   - Even row: the sample is written to linebuf[col].
//   - Odd row, even col: the sample is stored in hold (this is p10).
//   - Odd row, odd col: the quad is formed:
//       p00 = linebuf[col-1], p01 = linebuf[col], p10 = hold, p11 = sample.
//     Then out_valid = 1 and out_pixel is loaded on the next edge. Latency is
//     1 cycle from this accept.
//   - Channel mapping by BAYER_MODE:
//       RGGB: R=p00, G=avg(p01,p10), B=p11
//       GRBG: R=p01, G=avg(p00,p11), B=p10
//       GBRG: R=p10, G=avg(p00,p11), B=p01
//       BGGR: R=p11, G=avg(p01,p10), B=p00
//   - avg uses a PIX_W+1 bit sum, rounded per ROUND. The result never overflows
//     PIX_W.
//   - out_eol = 1 when the quad is at col = IMG_WIDTH-1. out_eof = 1 when it is
//     also at row = IMG_HEIGHT-1.
//   - Output hold: while out_valid && !out_ready, out_pixel, out_eol and out_eof
//     stay stable, and no sample is accepted. out_valid clears when accepted
//     unless a new quad is loaded in the same cycle.
//   - rst mid-frame: all state listed above clears immediately. Any pending
//     output is dropped. The next accepted sample is (0,0).
// TESTING
//   1. W=4,H=2,RGGB,ROUND=0. Send rows 10,20,30,40 / 50,60,70,80 ->
//      out 0xFF0A233C, then 0xFF1E3750 with out_eol=1 and out_eof=1.
//   2. Same data with BAYER_MODE=3 -> 0xFF3C230A, then 0xFF50371E.
//   3. ROUND: green pair 254,255 -> G=0xFE when ROUND=0, 0xFF when ROUND=1.
//      Pair 255,255 -> 0xFF in both modes.
//   4. Backpressure: hold out_ready=0 for 5 cycles after a quad. out_valid stays 1,
//      in_ready stays 0 and out_pixel is stable. Release -> one transfer only.
//   5. Assert in_sof on sample (1,2) -> sof_err pulses 1 cycle. The next quad uses
//      the new frame data only, and no output appears until its odd row.
//   6. Assert rst after 3 samples of row 1 -> out_valid=0 with no output emitted.
//      Resend the full frame -> identical to scenario 1.

Source files
------------

// File: rtl/debayer_stream.sv
// Streaming 2x2 Bayer-to-ARGB converter. One raw sample is accepted per handshake.
// Each completed quad on an odd row yields one registered half-resolution pixel.
module debayer_stream #(
  parameter int                PIX_W      = 8,
  parameter int                IMG_WIDTH  = 640,
  parameter int                IMG_HEIGHT = 480,
  parameter int                BAYER_MODE = 0,
  parameter int                ROUND      = 0,
  parameter logic [PIX_W-1:0]  ALPHA      = PIX_W'(8'hFF)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PIX_W-1:0]     in_pixel,
  input  logic                 in_sof,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*PIX_W-1:0]   out_pixel,
  output logic                 out_eol,
  output logic                 out_eof,
  output logic                 sof_err
);

  localparam int              CW       = $clog2(IMG_WIDTH);
  localparam int              RW       = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0]   COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0]   ROW_LAST = RW'(IMG_HEIGHT - 1);

  function automatic logic [PIX_W-1:0] avg(input logic [PIX_W-1:0] a,
                                           input logic [PIX_W-1:0] b);
    logic [PIX_W:0] sum;
    sum = {1'b0, a} + {1'b0, b} + (PIX_W+1)'(ROUND);
    return sum[PIX_W:1];
  endfunction

  logic [CW-1:0]        col_q, col_d;
  logic [RW-1:0]        row_q, row_d;
  logic [PIX_W-1:0]     hold_q, hold_d;
  logic                 out_valid_q, out_valid_d;
  logic [4*PIX_W-1:0]   out_pixel_q, out_pixel_d;
  logic                 out_eol_q, out_eol_d;
  logic                 out_eof_q, out_eof_d;
  logic                 sof_err_q, sof_err_d;

  logic [PIX_W-1:0]     linebuf [IMG_WIDTH];
  logic                 lb_we;
  logic                 accept;
  logic [CW-1:0]        eff_col;
  logic [RW-1:0]        eff_row;
  logic [PIX_W-1:0]     p00, p01, p10, p11;
  logic [PIX_W-1:0]     ch_r, ch_g, ch_b;

  assign in_ready  = !out_valid_q || out_ready;
  assign accept    = in_valid && in_ready;
  // A start-of-frame sample is positioned at (0,0) regardless of the counters.
  assign eff_col   = in_sof ? '0 : col_q;
  assign eff_row   = in_sof ? '0 : row_q;

  assign p00 = linebuf[{eff_col[CW-1:1], 1'b0}];
  assign p01 = linebuf[eff_col];
  assign p10 = hold_q;
  assign p11 = in_pixel;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
    ch_r = p00;
    ch_g = avg(p01, p10);
    ch_b = p11;
    case (BAYER_MODE)
      1: begin ch_r = p01; ch_g = avg(p00, p11); ch_b = p10; end
      2: begin ch_r = p10; ch_g = avg(p00, p11); ch_b = p01; end
      3: begin ch_r = p11; ch_g = avg(p01, p10); ch_b = p00; end
      default: ;
    endcase
  end

  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    hold_d      = hold_q;
    out_valid_d = out_valid_q && !out_ready;
    out_pixel_d = out_pixel_q;
    out_eol_d   = out_eol_q;
    out_eof_d   = out_eof_q;
    sof_err_d   = 1'b0;
    lb_we       = 1'b0;

    if (accept) begin
      sof_err_d = in_sof && ((col_q != '0) || (row_q != '0));
      if (eff_col == COL_LAST) begin
        col_d = '0;
        row_d = (eff_row == ROW_LAST) ? '0 : eff_row + RW'(1);
      end else begin
        col_d = eff_col + CW'(1);
        row_d = eff_row;
      end

      if (!eff_row[0]) begin
        lb_we = 1'b1;
      end else if (!eff_col[0]) begin
        hold_d = in_pixel;
      end else begin
        out_valid_d = 1'b1;
        out_pixel_d = {ALPHA, ch_r, ch_g, ch_b};
        out_eol_d   = (eff_col == COL_LAST);
        out_eof_d   = (eff_col == COL_LAST) && (eff_row == ROW_LAST);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q       <= '0;
      row_q       <= '0;
      hold_q      <= '0;
      out_valid_q <= 1'b0;
      out_pixel_q <= '0;
      out_eol_q   <= 1'b0;
      out_eof_q   <= 1'b0;
      sof_err_q   <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      hold_q      <= hold_d;
      out_valid_q <= out_valid_d;
      out_pixel_q <= out_pixel_d;
      out_eol_q   <= out_eol_d;
      out_eof_q   <= out_eof_d;
      sof_err_q   <= sof_err_d;
    end
  end

  // NOTE: the line buffer has no reset; every entry is written on an even row before an odd row reads it.
  always_ff @(posedge clk) begin
    if (lb_we) linebuf[eff_col] <= in_pixel;
  end

  assign out_valid = out_valid_q;
  assign out_pixel = out_pixel_q;
  assign out_eol   = out_eol_q;
  assign out_eof   = out_eof_q;
  assign sof_err   = sof_err_q;

endmodule
